monitor_report_sched: RTL

// - Collects the one-hot report outputs of an LTL monitor automata stage and turns them into a serial

---
 rtl/monitor_pkg.sv | 14 +
 rtl/report_fifo.sv | 56 +++++
 rtl/monitor_report_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/monitor_pkg.sv
// Constants and entry layout shared between the report scheduler and the monitor cluster stage wrappers.
package monitor_pkg;

   localparam int N_REPORTS  = 40;
   localparam int ID_W       = 6;
   localparam int STAMP_W    = 32;
   localparam int FIFO_DEPTH = 8;

   typedef struct packed {
      logic [ID_W-1:0]    id;
      logic [STAMP_W-1:0] stamp;
   } report_entry_t;

endpackage

// File: rtl/report_fifo.sv
// Synchronous FIFO with combinational head output; the clear input empties it on the next edge.
module report_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop & (count_reg != '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (!full | do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= din;
   end

   assign dout  = mem[rd_ptr_reg];
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/monitor_report_sched.sv
// Serialises one-hot monitor reports into {id, stamp} entries, stalling the symbol feed
// while a captured snapshot is still draining.
module monitor_report_sched #(
   parameter int N_REPORTS  = monitor_pkg::N_REPORTS,
   parameter int ID_W       = monitor_pkg::ID_W,
   parameter int STAMP_W    = monitor_pkg::STAMP_W,
   parameter int FIFO_DEPTH = monitor_pkg::FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 run,
   input  logic [N_REPORTS-1:0] reports_i,
   input  logic                 clear,
   output logic                 stall_o,
   output logic                 rpt_valid,
   input  logic                 rpt_ready,
   output logic [ID_W-1:0]      rpt_id,
   output logic [STAMP_W-1:0]   rpt_stamp,
   output logic                 overflow,
   output logic                 busy
);

   localparam int ENTRY_W = ID_W + STAMP_W;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [N_REPORTS-1:0] ONE = {{(N_REPORTS-1){1'b0}}, 1'b1};

   function automatic logic [ID_W-1:0] lowest_set(input logic [N_REPORTS-1:0] v);
      lowest_set = '0;
      for (int i = N_REPORTS - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = ID_W'(i);
      end
   endfunction

   logic [STAMP_W-1:0]   sym_cnt_reg;
   logic [STAMP_W-1:0]   stamp_d_reg;
   logic                 run_d_reg;
   logic [N_REPORTS-1:0] snap_reg;
   logic [N_REPORTS-1:0] snap_next;
   logic [STAMP_W-1:0]   snap_stamp_reg;
   logic                 snap_valid_reg;
   logic                 overflow_reg;
   logic [ID_W-1:0]      low_id;
   logic                 hit;
   logic                 pop;
   logic                 push;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;
   logic [ENTRY_W-1:0]   fifo_dout;

   assign hit       = run_d_reg & (|reports_i);
   assign stall_o   = snap_valid_reg | hit;
   assign pop       = rpt_valid & rpt_ready;
   assign push      = snap_valid_reg & (!fifo_full | pop);
   assign low_id    = lowest_set(snap_reg);
   assign snap_next = snap_reg & ~(ONE << low_id);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sym_cnt_reg    <= '0;
         stamp_d_reg    <= '0;
         run_d_reg      <= 1'b0;
         snap_reg       <= '0;
         snap_stamp_reg <= '0;
         snap_valid_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else if (clear) begin
         sym_cnt_reg    <= '0;
         stamp_d_reg    <= '0;
         run_d_reg      <= 1'b0;
         snap_reg       <= '0;
         snap_stamp_reg <= '0;
         snap_valid_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         if (run) begin
            sym_cnt_reg <= sym_cnt_reg + 1'b1;
            stamp_d_reg <= sym_cnt_reg;
         end
         run_d_reg <= run;
         // Capture and drain are exclusive: drain needs snap_valid, capture needs it clear.
         if (hit && !snap_valid_reg) begin
            snap_reg       <= reports_i;
            snap_stamp_reg <= stamp_d_reg;
            snap_valid_reg <= 1'b1;
         end else begin
            if (hit) overflow_reg <= 1'b1;
            if (push) begin
               snap_reg       <= snap_next;
               snap_valid_reg <= |snap_next;
            end
         end
      end
   end

   report_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .push    (push),
      .pop     (pop),
      .din     ({low_id, snap_stamp_reg}),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign rpt_valid = !fifo_empty;
   assign rpt_id    = fifo_dout[ENTRY_W-1:STAMP_W];
   assign rpt_stamp = fifo_dout[STAMP_W-1:0];
   assign overflow  = overflow_reg;
   assign busy      = snap_valid_reg | (fifo_count != '0);

endmodule
